sumador_secuencial_ctrl: RTL and testbench

//  Sequential operand feeder and result capture around the 8-bit ripple adder (SUM_RIZADO).
//  - Accepts operand bytes over a valid/ready handshake and drives them onto the adder inputs.
//  - Waits a fixed number of cycles for the ripple carry to settle, then registers s/co.
//  - Chains the carry across consecutive bytes, giving multi-byte (LSB-first) addition.

---
 rtl/sumador_secuencial_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sumador_secuencial_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_secuencial_ctrl.sv
// Operand feeder and result capture around an external 8-bit ripple adder, with carry chaining
// for LSB-first multi-byte sums. Define ACT_CNT_EN to add the act_cnt switching-activity counter.
module sumador_secuencial_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_first,
  input  logic             in_ci,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_ci,
  input  logic [7:0]       add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_s,
  output logic             out_co,
  output logic             busy
`ifdef ACT_CNT_EN
  ,
  output logic [CNT_W-1:0] act_cnt
`endif
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int SC_W       = $clog2(SETTLE_EFF + 1) + 1;
  localparam logic [SC_W-1:0] CNT_LOAD = SC_W'(SETTLE_EFF);
  localparam logic [SC_W-1:0] CNT_ONE  = SC_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            accept_s;
  logic            capture_s;
  logic            release_s;
  logic            new_ci_s;
  logic [SC_W-1:0] cnt_r;
  logic            carry_r;

  assign new_ci_s = in_first ? in_ci : carry_r;

  // State register; handshake flags are registered from the next state
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_r  <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_s;
      in_ready <= (state_s == IDLE);
      busy     <= (state_s != IDLE);
    end
  end

  // Next-state decode and transfer strobes
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = SETTLE;
        end else begin
          state_s  = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_r == CNT_ONE) begin
          capture_s = 1'b1;
          state_s   = HOLD;
        end else begin
          state_s   = SETTLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Adder drive, settle countdown, result capture and carry chaining
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      add_a     <= 8'h00;
      add_b     <= 8'h00;
      add_ci    <= 1'b0;
      cnt_r     <= {SC_W{1'b0}};
      out_s     <= 8'h00;
      out_co    <= 1'b0;
      out_valid <= 1'b0;
      carry_r   <= 1'b0;
    end else begin
      // adder inputs move only on acceptance so idle cycles add no toggles
      if (accept_s) begin
        add_a  <= in_a;
        add_b  <= in_b;
        add_ci <= new_ci_s;
        cnt_r  <= CNT_LOAD;
      end else if (state_r == SETTLE) begin
        cnt_r  <= cnt_r - CNT_ONE;
      end
      if (capture_s) begin
        out_s     <= add_s;
        out_co    <= add_co;
        carry_r   <= add_co;
        out_valid <= 1'b1;
      end else if (release_s) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ACT_CNT_EN
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic [4:0]       delta_s;
  logic [CNT_W+4:0] sum_s;

  // Hamming distance between the new and current adder inputs
  always_comb begin
    delta_s = {1'b0, popcount8(in_a ^ add_a)} + {1'b0, popcount8(in_b ^ add_b)}
              + {4'd0, new_ci_s ^ add_ci};
    sum_s   = {5'd0, act_cnt} + (CNT_W + 5)'(delta_s);
  end

  // Saturating switching-activity accumulator
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      act_cnt <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (sum_s > {5'd0, {CNT_W{1'b1}}}) begin
        act_cnt <= {CNT_W{1'b1}};
      end else begin
        act_cnt <= sum_s[CNT_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sumador_secuencial_ctrl.sv
// Directed bench for sumador_secuencial_ctrl: a behavioural ripple adder closes the loop and
// each scenario task checks the outputs against hand-computed values.
module tb_sumador_secuencial_ctrl;

  localparam int SETTLE = 2;
  localparam int CNTW   = 4;
  localparam int LAT    = (SETTLE < 1) ? 1 : SETTLE;

  logic clk = 1'b0;
  logic reset_L, in_valid, in_ready, in_first, in_ci;
  logic [7:0] in_a, in_b, add_a, add_b, add_s, out_s;
  logic add_ci, add_co, out_valid, out_ready, out_co, busy;
`ifdef ACT_CNT_EN
  logic [CNTW-1:0] act_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // external adder
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_ci};

  sumador_secuencial_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNTW)) dut (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_ci(in_ci),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_co(out_co),
    .busy(busy)
`ifdef ACT_CNT_EN
    , .act_cnt(act_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 8'h00; in_b = 8'h00; in_first = 1'b0; in_ci = 1'b0;
    tick(); tick();
    reset_L = 1'b1;
  endtask

  // present a byte, wait for acceptance, then count edges until out_valid
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic first,
                      input logic ci, output int lat);
    int guard;
    in_a = a; in_b = b; in_first = first; in_ci = ci; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick(); guard++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick(); lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_s, out_co} !== 10'd0) begin
      n_fail++; $display("FAIL reset_out: valid/s/co=%h required 000", {out_valid, out_s, out_co});
    end
    n_checks++;
    if ({add_a, add_b, add_ci} !== 17'd0) begin
      n_fail++; $display("FAIL reset_add: a/b/ci=%h required 00000", {add_a, add_b, add_ci});
    end
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic_add();
    int lat;
    send(8'h12, 8'h34, 1'b1, 1'b0, lat);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL latency: %0d edges required %0d", lat, LAT);
    end
    n_checks++;
    if (out_s !== 8'h46 || out_co !== 1'b0) begin
      n_fail++; $display("FAIL add_12_34: s=%h co=%b required 46 0", out_s, out_co);
    end
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL hold_flags: busy=%b in_ready=%b required 1 0", busy, in_ready);
    end
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    send(8'hFF, 8'h01, 1'b1, 1'b0, lat);
    n_checks++;
    if (out_s !== 8'h00 || out_co !== 1'b1) begin
      n_fail++; $display("FAIL chain_lsb: s=%h co=%b required 00 1", out_s, out_co);
    end
    release_out();
    send(8'h00, 8'h00, 1'b0, 1'b0, lat);
    n_checks++;
    if (out_s !== 8'h01 || out_co !== 1'b0) begin
      n_fail++; $display("FAIL chain_msb: s=%h co=%b required 01 0", out_s, out_co);
    end
    release_out();
  endtask

  task automatic test_hold();
    int lat;
    send(8'h80, 8'h80, 1'b1, 1'b1, lat);
    n_checks++;
    if (out_s !== 8'h01 || out_co !== 1'b1) begin
      n_fail++; $display("FAIL add_80_80: s=%h co=%b required 01 1", out_s, out_co);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_s !== 8'h01 || in_ready !== 1'b0 || add_a !== 8'h80) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%b s=%h in_ready=%b add_a=%h required 1 01 0 80",
                 out_valid, out_s, in_ready, add_a);
      end
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(8'h10, 8'h20, 1'b1, 1'b0, lat);
    in_valid = 1'b1; in_a = 8'h05; in_b = 8'h06;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (add_a !== 8'h10 || out_s !== 8'h30) begin
      n_fail++; $display("FAIL no_recapture: add_a=%h s=%h required 10 30", add_a, out_s);
    end
    release_out();
    n_checks++;
    if (add_a !== 8'h10 || busy !== 1'b0) begin
      n_fail++; $display("FAIL no_passthru: add_a=%h busy=%b required 10 0", add_a, busy);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (add_a !== 8'h05 || add_b !== 8'h06 || busy !== 1'b1) begin
      n_fail++; $display("FAIL accept_idle: a=%h b=%h busy=%b required 05 06 1", add_a, add_b, busy);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick(); lat++;
    end
    n_checks++;
    if (out_s !== 8'h0B || out_co !== 1'b0) begin
      n_fail++; $display("FAIL add_05_06: s=%h co=%b required 0b 0", out_s, out_co);
    end
    release_out();
  endtask

  task automatic test_reset_in_flight();
    int lat;
    send(8'hFF, 8'h01, 1'b1, 1'b0, lat);
    release_out();
    in_a = 8'h33; in_b = 8'h44; in_first = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || add_a !== 8'h00) begin
      n_fail++; $display("FAIL abort: valid=%b in_ready=%b busy=%b add_a=%h required 0 1 0 00",
                         out_valid, in_ready, busy, add_a);
    end
    send(8'h01, 8'h01, 1'b0, 1'b1, lat);
    n_checks++;
    if (out_s !== 8'h02 || out_co !== 1'b0) begin
      n_fail++; $display("FAIL carry_cleared: s=%h co=%b required 02 0", out_s, out_co);
    end
    release_out();
  endtask

`ifdef ACT_CNT_EN
  task automatic test_act_cnt();
    int lat;
    do_reset();
    send(8'hFF, 8'h00, 1'b1, 1'b1, lat);
    n_checks++;
    if (act_cnt !== 4'd9) begin
      n_fail++; $display("FAIL act_first: act_cnt=%0d required 9", act_cnt);
    end
    release_out();
    send(8'h0F, 8'h00, 1'b1, 1'b1, lat);
    n_checks++;
    if (act_cnt !== 4'd13) begin
      n_fail++; $display("FAIL act_second: act_cnt=%0d required 13", act_cnt);
    end
    release_out();
    send(8'hFF, 8'h00, 1'b1, 1'b1, lat);
    n_checks++;
    if (act_cnt !== 4'd15) begin
      n_fail++; $display("FAIL act_saturate: act_cnt=%0d required 15", act_cnt);
    end
    release_out();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_hold();
    test_back_to_back();
    test_reset_in_flight();
`ifdef ACT_CNT_EN
    test_act_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
